// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Optional feature macro TX_ARB_PRIORITY_EN: requester 0 overrides the rotation.
module uart_tx_arbiter #(
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [ID_W-1:0]   grant_q, grant_d;

  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  win_onehot;
  logic              found;
  logic              ptr_upd;
  logic [ID_W-1:0]   win;
  logic [7:0]        win_data;

  // Winner search: first pass covers indices at or above the pointer, second pass wraps.
  always_comb begin
    cand       = req_valid;
    found      = 1'b0;
    win        = '0;
    ptr_upd    = 1'b1;
    win_data   = '0;
    win_onehot = '0;
`ifdef TX_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      found   = 1'b1;
      win     = '0;
      ptr_upd = 1'b0;
    end
    cand[0] = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && cand[i] && (ID_W'(i) >= ptr_q)) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (found && (win == ID_W'(i))) begin
        win_data      = req_data[8*i +: 8];
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready = win_onehot;
          tx_data_d = win_data;
          grant_d   = win;
          if (ptr_upd) ptr_d = (win == LAST_ID) ? '0 : win + ID_W'(1);
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register so reset clears them without a clock.
  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q != IDLE);
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      tx_data_q <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: instance a has a 16-cycle gap, instance b has no gap.
module tb_uart_tx_arbiter;

`ifdef TX_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;

  logic [2:0]  a_req_valid, a_req_ready;
  logic [23:0] a_req_data;
  logic [7:0]  a_tx_data;
  logic        a_tx_valid, a_tx_ready, a_busy;
  logic [1:0]  a_grant_id;

  logic [2:0]  b_req_valid, b_req_ready;
  logic [23:0] b_req_data;
  logic [7:0]  b_tx_data;
  logic        b_tx_valid, b_tx_ready, b_busy;
  logic [1:0]  b_grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(3), .GAP_CYCLES(16)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_data(a_req_data), .req_ready(a_req_ready),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .grant_id(a_grant_id), .busy(a_busy)
  );

  uart_tx_arbiter #(.N_REQ(3), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_data(b_req_data), .req_ready(b_req_ready),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .grant_id(b_grant_id), .busy(b_busy)
  );

  task automatic wait_idle_a(input string tag);
    int cyc;
    cyc = 0;
    while (a_busy && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    n_checks++;
    if (a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b required 0 within 100 cycles", tag, a_busy);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    n_checks++; if (a_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", a_tx_valid); end
    n_checks++; if (a_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", a_tx_data); end
    n_checks++; if (a_req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_req_ready: got %b want 000", a_req_ready); end
    n_checks++; if (a_grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d want 0", a_grant_id); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++; if (a_busy !== 1'b0 || a_tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: busy=%b tx_valid=%b want 0 0", a_busy, a_tx_valid); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_id;
    logic [7:0] exp_byte;
    logic [2:0] exp_rdy;
    @(posedge clk); #1;
    b_req_data  = {8'hC2, 8'hB1, 8'hA0};
    b_req_valid = 3'b111;
    b_tx_ready  = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_id   = PRIO ? 2'd0 : 2'(k % 3);
      exp_rdy  = 3'b001 << exp_id;
      exp_byte = (exp_id == 2'd0) ? 8'hA0 : (exp_id == 2'd1) ? 8'hB1 : 8'hC2;
      n_checks++;
      if (b_req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL fair_req_ready[%0d]: got %b want %b", k, b_req_ready, exp_rdy);
      end
      @(posedge clk); #2;
      n_checks++;
      if (b_tx_valid !== 1'b1 || b_grant_id !== exp_id || b_tx_data !== exp_byte) begin
        n_fail++;
        $display("FAIL fair_send[%0d]: valid=%b id=%0d data=%h want 1 %0d %h", k, b_tx_valid, b_grant_id, b_tx_data, exp_id, exp_byte);
      end
      @(posedge clk); #2;
    end
    b_req_valid = 3'b000;
  endtask

  task automatic test_single_byte();
    @(posedge clk); #1;
    a_req_data  = {8'h33, 8'h5A, 8'h11};
    a_req_valid = 3'b010;
    a_tx_ready  = 1'b1;
    #1;
    n_checks++; if (a_req_ready !== 3'b010) begin n_fail++; $display("FAIL single_req_ready: got %b want 010", a_req_ready); end
    @(posedge clk); #1;
    a_req_valid = 3'b000;
    a_req_data  = 24'hFFFFFF;
    #1;
    n_checks++; if (a_tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_tx_valid: got %b want 1", a_tx_valid); end
    n_checks++; if (a_tx_data !== 8'h5A) begin n_fail++; $display("FAIL single_tx_data: got %h want 5a", a_tx_data); end
    n_checks++; if (a_grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant_id: got %0d want 1", a_grant_id); end
    n_checks++; if (a_req_ready !== 3'b000) begin n_fail++; $display("FAIL single_no_ready: got %b want 000", a_req_ready); end
    @(posedge clk); #2;
    n_checks++; if (a_tx_valid !== 1'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL single_handshake: valid=%b busy=%b want 0 1", a_tx_valid, a_busy); end
    wait_idle_a("single");
  endtask

  task automatic test_gap();
    logic [2:0] first_rdy;
    logic [7:0] first_byte;
    first_rdy  = PRIO ? 3'b001 : 3'b100;
    first_byte = PRIO ? 8'h0A : 8'hC3;
    @(posedge clk); #1;
    a_req_data  = {8'hC3, 8'h00, 8'h0A};
    a_req_valid = 3'b101;
    a_tx_ready  = 1'b1;
    #1;
    n_checks++; if (a_req_ready !== first_rdy) begin n_fail++; $display("FAIL gap_first_ready: got %b want %b", a_req_ready, first_rdy); end
    @(posedge clk); #2;
    n_checks++; if (a_tx_valid !== 1'b1 || a_tx_data !== first_byte) begin n_fail++; $display("FAIL gap_first_send: valid=%b data=%h want 1 %h", a_tx_valid, a_tx_data, first_byte); end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #2;
      n_checks++;
      if (a_req_ready !== 3'b000 || a_busy !== 1'b1 || a_tx_valid !== 1'b0) begin
        n_fail++; $display("FAIL gap_hold[%0d]: ready=%b busy=%b valid=%b want 000 1 0", k, a_req_ready, a_busy, a_tx_valid);
      end
    end
    @(posedge clk); #2;
    n_checks++; if (a_req_ready !== 3'b001) begin n_fail++; $display("FAIL gap_second_ready: got %b want 001", a_req_ready); end
    @(posedge clk); #1;
    a_req_valid = 3'b000;
    #1;
    n_checks++; if (a_tx_data !== 8'h0A || a_grant_id !== 2'd0) begin n_fail++; $display("FAIL gap_second_send: data=%h id=%0d want 0a 0", a_tx_data, a_grant_id); end
    wait_idle_a("gap");
  endtask

  task automatic test_stall();
    @(posedge clk); #1;
    a_req_data  = {8'h99, 8'h77, 8'h55};
    a_req_valid = 3'b010;
    a_tx_ready  = 1'b0;
    #1;
    n_checks++; if (a_req_ready !== 3'b010) begin n_fail++; $display("FAIL stall_capture: got %b want 010", a_req_ready); end
    @(posedge clk); #1;
    a_req_valid = 3'b111;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin @(posedge clk); #2; end
      n_checks++;
      if (a_tx_valid !== 1'b1 || a_tx_data !== 8'h77 || a_req_ready !== 3'b000) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b data=%h ready=%b want 1 77 000", k, a_tx_valid, a_tx_data, a_req_ready);
      end
    end
    @(posedge clk); #1;
    a_tx_ready = 1'b1;
    #1;
    n_checks++; if (a_tx_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %b want 1", a_tx_valid); end
    @(posedge clk); #2;
    n_checks++; if (a_tx_valid !== 1'b0 || a_req_ready !== 3'b000) begin n_fail++; $display("FAIL stall_done: valid=%b ready=%b want 0 000", a_tx_valid, a_req_ready); end
    a_req_valid = 3'b000;
    wait_idle_a("stall");
  endtask

  task automatic test_reset_mid_send();
    @(posedge clk); #1;
    a_req_data  = {8'h03, 8'h02, 8'h01};
    a_req_valid = 3'b001;
    a_tx_ready  = 1'b0;
    #1;
    n_checks++; if (a_req_ready !== 3'b001) begin n_fail++; $display("FAIL rms_capture: got %b want 001", a_req_ready); end
    @(posedge clk); #1;
    a_req_valid = 3'b000;
    #1;
    n_checks++; if (a_tx_valid !== 1'b1) begin n_fail++; $display("FAIL rms_in_send: got %b want 1", a_tx_valid); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (a_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rms_async_valid: got %b want 0", a_tx_valid); end
    n_checks++; if (a_busy !== 1'b0 || a_tx_data !== 8'h00) begin n_fail++; $display("FAIL rms_async_clear: busy=%b data=%h want 0 00", a_busy, a_tx_data); end
    @(posedge clk); #1;
    reset       = 1'b0;
    a_req_valid = 3'b111;
    #1;
    n_checks++; if (a_req_ready !== 3'b001) begin n_fail++; $display("FAIL rms_ptr_reset: got %b want 001", a_req_ready); end
    @(posedge clk); #1;
    a_req_valid = 3'b000;
    a_tx_ready  = 1'b1;
    #1;
    n_checks++; if (a_grant_id !== 2'd0 || a_tx_data !== 8'h01) begin n_fail++; $display("FAIL rms_regrant: id=%0d data=%h want 0 01", a_grant_id, a_tx_data); end
    wait_idle_a("rms");
  endtask

  initial begin
    reset       = 1'b1;
    a_req_valid = '0; a_req_data = '0; a_tx_ready = 1'b0;
    b_req_valid = '0; b_req_data = '0; b_tx_ready = 1'b0;
    test_reset();
    test_fairness();
    test_single_byte();
    test_gap();
    test_stall();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between several byte producers (wall-detection report, status/telemetry, acknowledge bytes). Sits between the requesters and the uart `tx_data`/`tx_valid`/`tx_ready` port. It captures one byte from the granted requester, presents it to the UART with a valid/ready handshake, then enforces a programmable inter-byte gap. Arbitration is round-robin, with an optional strict-priority override for requester 0.

## Interface
- `N_REQ`, default 3: number of requesters, 2..8.
- `GAP_CYCLES`, default 16: idle clk cycles inserted after each accepted byte; 0 means no gap.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: bit i high means requester i has a byte ready.
- `req_data` in 8*N_REQ: byte of requester i in bits [8i+7:8i].
- `req_ready` out N_REQ: one-hot, one-cycle pulse; the byte of requester i is captured this cycle.
- `tx_data` out 8: byte to UART.
- `tx_valid` out 1: `tx_data` valid to UART.
- `tx_ready` in 1: UART can accept a byte.
- `grant_id` out $clog2(N_REQ): index of the last captured requester.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, SEND, GAP.
- **IDLE**
  - If any `req_valid` is high, select a winner i.
  - Pulse `req_ready[i]`, latch `req_data[i]` into `tx_data`, and set `grant_id` to i.
  - Set the round-robin pointer to (i+1) mod N_REQ, then go to SEND.
  - With no request, stay in IDLE.
- **Round-robin selection:** the winner is the first asserted `req_valid` scanning upward from the pointer, wrapping at N_REQ. The pointer resets to 0.
- **SEND**
  - `tx_valid`=1 and `tx_data` is held stable.
  - On `tx_valid && tx_ready`, go to GAP, loading the counter with GAP_CYCLES-1, or go straight to IDLE if GAP_CYCLES=0.
  - `tx_ready` low stalls SEND indefinitely. There is no timeout.
- **GAP:** the counter decrements each cycle. At 0, go to IDLE. `tx_valid`=0.
- **Requester behaviour after capture**
  - A requester may drop `req_valid` or change `req_data` after its `req_ready` pulse. The latched byte is unaffected.
  - A requester that still holds `req_valid` is treated as a new byte.
- **Capture conditions:** requests arriving in SEND or GAP are not captured. `req_ready` stays 0 outside IDLE.
- **Width rules**
  - Gap counter width is $clog2(GAP_CYCLES+1).
  - The pointer wraps modulo N_REQ, including when N_REQ is not a power of 2.
  - `req_ready` is never asserted for an index ≥ N_REQ.
- **Reset mid-operation:** any state returns to IDLE immediately. `tx_valid` drops asynchronously and the in-flight byte is discarded.

## Timing
- **Reset values:**
  - `tx_valid`=0, `tx_data`=8'h00, `req_ready`=0, `grant_id`=0, `busy`=0.
  - Internal: pointer=0, state=IDLE, gap counter=0.
- **Capture to UART:** capture on cycle N (`req_ready` high, combinational from IDLE and `req_valid`). `tx_valid` and `busy` are registered high from N+1.
- **Handshake:** completes on the first cycle M ≥ N+1 where `tx_ready`=1. `tx_valid` is low at M+1.
- **Next capture:**
  - Earliest at M+1+GAP_CYCLES.
  - With GAP_CYCLES=0, earliest at M+1, giving a back-to-back byte every 2 cycles when `tx_ready` is held high.
- **Stable outputs:** `grant_id` and `tx_data` change only on capture cycles.

## Configuration
- **`TX_ARB_PRIORITY_EN` defined:** requester 0 wins whenever its `req_valid` is high in IDLE, regardless of the pointer. The other requesters arbitrate round-robin among themselves, and the pointer is not updated on a requester-0 grant.
- **`TX_ARB_PRIORITY_EN` undefined:** pure round-robin over all N_REQ requesters.

## Test plan
- **Single byte:** `req_valid`=3'b010 with byte 8'h5A, `tx_ready`=1 → `req_ready`=3'b010 for one cycle; `tx_data`=8'h5A and `tx_valid`=1 on the next cycle; `grant_id`=1; handshake completes on that cycle.
- **Fairness:** hold `req_valid`=3'b111 from reset with GAP_CYCLES=0 → grant order 0,1,2,0,1,2; a byte every 2 cycles.
- **Gap:** GAP_CYCLES=16, two back-to-back requests → the second `req_ready` comes exactly 17 cycles after the first handshake cycle; `busy`=1 throughout GAP.
- **Stall:** hold `tx_ready`=0 for 100 cycles in SEND → `tx_valid` stays 1 and `tx_data` stays stable; no `req_ready` pulses; completes one cycle after `tx_ready` rises.
- **Reset mid-SEND:** assert `reset` while `tx_valid`=1 → `tx_valid`=0 without waiting for a clock edge; after release, the next grant starts from requester 0.
- **`TX_ARB_PRIORITY_EN`:** hold `req_valid`=3'b111 → requester 0 granted every time; under the same stimulus without the macro, order is 0,1,2.
